// File: rtl/sdram_stream_reader.sv
// Read-side DMA client: issues sequential word reads on the arbiter request port,
// buffers responses in a credit-guarded FIFO and streams them out. Optional macro: STREAM_READER_PREFETCH_EN.
module sdram_stream_reader #(
   parameter int ADDR_W     = 23,
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 16,
   parameter int ADDR_STEP  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              idle,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_rw,
   output logic              mem_in_valid,
   input  logic              mem_busy,
   input  logic              mem_out_valid,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              mem_prefetch_step,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  issued_left_q, issued_left_d;
   logic [LEN_W-1:0]  pop_left_q, pop_left_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

   logic [CNT_W:0]    credit_used;
   logic              req_accept;
   logic              push;
   logic              pop;

   // Every issued request owns a FIFO slot until its word is popped.
   assign credit_used  = {1'b0, outstanding_q} + {1'b0, count_q};
   assign mem_in_valid = (state_q == S_ISSUE) && (issued_left_q != '0) &&
                         (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign req_accept   = mem_in_valid & ~mem_busy;
   assign push         = mem_out_valid;
   assign m_valid      = (count_q != '0);
   assign pop          = m_valid & m_ready;
   assign m_data       = fifo_mem[rd_ptr_q];
   assign m_last       = m_valid && (pop_left_q == LEN_W'(1));

   assign idle        = (state_q == S_IDLE);
   assign done        = (state_q == S_DONE);
   assign mem_address = addr_q;
   assign mem_rw      = 1'b0;

`ifdef STREAM_READER_PREFETCH_EN
   assign mem_prefetch_step = mem_in_valid && (issued_left_q > LEN_W'(1));
`else
   assign mem_prefetch_step = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d       = state_q;
      addr_d        = addr_q;
      issued_left_d = issued_left_q;
      pop_left_d    = pop_left_q;

      if (req_accept) begin
         addr_d        = addr_q + ADDR_W'(ADDR_STEP);
         issued_left_d = issued_left_q - LEN_W'(1);
      end
      if (pop) begin
         pop_left_d = pop_left_q - LEN_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_d       = S_ISSUE;
                  addr_d        = base_addr;
                  issued_left_d = length;
                  pop_left_d    = length;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE: if (req_accept && issued_left_q == LEN_W'(1)) state_d = S_DRAIN;
         S_DRAIN: if (pop && pop_left_q == LEN_W'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      outstanding_d = outstanding_q;
      case ({req_accept, push})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         issued_left_q <= '0;
         pop_left_q    <= '0;
         outstanding_q <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         issued_left_q <= issued_left_d;
         pop_left_q    <= pop_left_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // NOTE: FIFO storage has no reset; count_q alone decides which entries are visible.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= mem_data_in;
   end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Self-checking bench for sdram_stream_reader: arbiter model with fixed response
// latency, address/data scoreboards, credit and done-timing checks.
module tb_sdram_stream_reader;

  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 16;
  localparam int ADDR_STEP  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LAT        = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              idle, done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_rw, mem_in_valid;
  logic              mem_busy = 1'b0;
  logic              mem_out_valid = 1'b0;
  logic [DATA_W-1:0] mem_data_in = '0;
  logic              mem_prefetch_step;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  sdram_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .ADDR_STEP(ADDR_STEP), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .idle(idle), .done(done), .mem_address(mem_address), .mem_rw(mem_rw),
    .mem_in_valid(mem_in_valid), .mem_busy(mem_busy), .mem_out_valid(mem_out_valid),
    .mem_data_in(mem_data_in), .mem_prefetch_step(mem_prefetch_step),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } resp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int fifo_cnt = 0;
  int done_cnt = 0;
  int exp_done_cyc = -10;

  resp_t             resp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  bit                exp_last_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {~a[8:0], a};
  endfunction

  // Arbiter response side: in-order data LAT cycles after acceptance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst) begin
      resp_q.delete();
      mem_out_valid = 1'b0;
    end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      mem_out_valid = 1'b1;
      mem_data_in   = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      mem_out_valid = 1'b0;
    end
  end

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_in_valid && !mem_busy) begin
        check("req_credit", (out_cnt + fifo_cnt < FIFO_DEPTH), 1'b1);
        if (exp_addr_q.size() == 0) begin
          check("req_extra", mem_in_valid, 1'b0);
        end else begin
          check("req_addr", mem_address, exp_addr_q[0]);
          check("req_rw", mem_rw, 1'b0);
`ifdef STREAM_READER_PREFETCH_EN
          check("prefetch", mem_prefetch_step, (exp_addr_q.size() > 1));
`else
          check("prefetch", mem_prefetch_step, 1'b0);
`endif
          void'(exp_addr_q.pop_front());
        end
        resp_q.push_back('{due: cyc + LAT, data: word_of(mem_address)});
        acc_cnt++;
        out_cnt++;
      end
      if (mem_out_valid) begin
        out_cnt--;
        fifo_cnt++;
      end
      if (m_valid && !m_ready && exp_data_q.size() > 0) begin
        check("stall_head", m_data, exp_data_q[0]);
      end
      if (m_valid && m_ready) begin
        if (exp_data_q.size() == 0) begin
          check("pop_extra", m_valid, 1'b0);
        end else begin
          check("m_data", m_data, exp_data_q[0]);
          check("m_last", m_last, exp_last_q[0]);
          if (exp_last_q[0]) exp_done_cyc = cyc + 1;
          void'(exp_data_q.pop_front());
          void'(exp_last_q.pop_front());
        end
        fifo_cnt--;
      end
      if (done) begin
        check("done_cycle", cyc, exp_done_cyc);
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic queue_xfer(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + ADDR_W'(i * ADDR_STEP);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(word_of(a));
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input int n);
    base_addr = b;
    length    = LEN_W'(n);
    start     = 1'b1;
    if (n == 0) exp_done_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int d0);
    int n = 0;
    while (!(idle === 1'b1 && exp_data_q.size() == 0) && n < 2000) begin
      tick();
      n++;
    end
    check(tag, (n < 2000), 1'b1);
    check("addr_left", exp_addr_q.size(), 0);
    check("done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d0;
    int a0;
    int n;

    repeat (3) tick();
    rst = 1'b0;
    // Reset state
    check("rst_idle", idle, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_valid", mem_in_valid, 1'b0);
    check("rst_addr", mem_address, 23'h0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_prefetch", mem_prefetch_step, 1'b0);
    tick();

    // Basic 4-word transfer
    d0 = done_cnt;
    queue_xfer(23'h000100, 4);
    pulse_start(23'h000100, 4);
    check("first_req_latency", mem_in_valid, 1'b1);
    wait_idle("t1_timeout", d0);

    // Zero length: done only, no requests
    d0 = done_cnt;
    pulse_start(23'h000500, 0);
    check("len0_done", done, 1'b1);
    check("len0_noreq", mem_in_valid, 1'b0);
    wait_idle("t2_timeout", d0);

    // Consumer stall: credit limit holds requests at FIFO_DEPTH
    d0 = done_cnt;
    a0 = acc_cnt;
    m_ready = 1'b0;
    queue_xfer(23'h001000, 20);
    pulse_start(23'h001000, 20);
    start = 1'b1;
    base_addr = 23'h005550;
    length = LEN_W'(3);
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("stall_acc", acc_cnt - a0, FIFO_DEPTH);
    check("stall_req_drop", mem_in_valid, 1'b0);
    check("stall_full", m_valid, 1'b1);
    m_ready = 1'b1;
    wait_idle("t3_timeout", d0);

    // Busy stall on request 2
    d0 = done_cnt;
    queue_xfer(23'h002000, 6);
    pulse_start(23'h002000, 6);
    tick();
    mem_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_addr", mem_address, 23'h002004);
      check("busy_valid", mem_in_valid, 1'b1);
      tick();
    end
    mem_busy = 1'b0;
    wait_idle("t4_timeout", d0);

    // Address wrap
    d0 = done_cnt;
    queue_xfer(23'h7FFFF8, 4);
    pulse_start(23'h7FFFF8, 4);
    wait_idle("t5_timeout", d0);

    // Reset mid-transfer, then a clean run
    a0 = acc_cnt;
    queue_xfer(23'h000300, 10);
    pulse_start(23'h000300, 10);
    n = 0;
    while (acc_cnt - a0 < 3 && n < 100) begin
      tick();
      n++;
    end
    check("t6_accepts", (acc_cnt - a0 >= 3), 1'b1);
    rst = 1'b1;
    tick();
    check("abort_idle", idle, 1'b1);
    check("abort_m_valid", m_valid, 1'b0);
    check("abort_req", mem_in_valid, 1'b0);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    out_cnt = 0;
    fifo_cnt = 0;
    exp_done_cyc = -10;
    rst = 1'b0;
    tick();
    d0 = done_cnt;
    queue_xfer(23'h000400, 5);
    pulse_start(23'h000400, 5);
    wait_idle("t6_timeout", d0);

    repeat (3) tick();
    if (errors == 0) $display("PASS CHECKS %0d ERRORS %0d", checks, errors);
    else             $display("FAIL CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
